// File: rtl/ovld_pkg.sv
// Shared constants and helpers for the output-valid AXI4-Stream adapter.
package ovld_pkg;

    localparam int   DEFAULT_DATA_WIDTH = 32;
    localparam logic TLAST_PER_BEAT     = 1'b1;

    // One extra MSB lets equal low bits distinguish full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ovld_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head data is read combinationally
// from registered storage at the registered read pointer.
module ovld_sync_fifo
    import ovld_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    // Write and read pointers, natural wrap.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
        end
    end

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/ovld_axis_adapter.sv
// Captures single-cycle result pulses into a FIFO and presents them as
// one-beat AXI4-Stream packets; a sticky flag records dropped results.
module ovld_axis_adapter
    import ovld_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    vld_in,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    input  logic                    ovf_clr
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_level;
    logic             r_overflow;

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign w_pop  = !w_empty && m_axis_tready;
    assign w_push = vld_in && (!w_full || w_pop);

    ovld_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (data_in),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level),
        .o_rdata (m_axis_tdata)
    );

    // Sticky drop flag; a drop in the same cycle as a clear takes priority.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_overflow <= 1'b0;
        end else if (vld_in && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    assign m_axis_tvalid = !w_empty;
    assign m_axis_tlast  = TLAST_PER_BEAT;
    assign level         = w_level;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_ovld_axis_adapter.sv
// Scoreboard bench: stimulus queues expected beats, a negedge monitor checks handshakes.
module tb_ovld_axis_adapter;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            aresetn;
    logic [DW-1:0]   data_in;
    logic            vld_in;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic [2:0]      level;
    logic            overflow;
    logic            ovf_clr;

    int              checks = 0;
    int              errors = 0;
    logic [DW-1:0]   exp_q [$];
    int              m_cnt = 0;
    logic            m_ovf = 1'b0;

    logic            prev_stall = 1'b0;
    logic [DW-1:0]   prev_data  = '0;

    ovld_axis_adapter #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .data_in       (data_in),
        .vld_in        (vld_in),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .level         (level),
        .overflow      (overflow),
        .ovf_clr       (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: inputs are settled at negedge, so a visible valid&ready is the beat of the next edge.
    always @(negedge clk) begin
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, m_axis_tvalid}, 32'd1);
                check("stall_data", m_axis_tdata, prev_data);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", m_axis_tdata, 32'hFFFF_FFFF ^ m_axis_tdata);
                end else begin
                    check("beat_data", m_axis_tdata, exp_q.pop_front());
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
        end
    end

    // Checks the state left by the previous edge, then drives one cycle and updates the model.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy, input logic clr);
        int pop_i;
        int acc_i;
        check("level", {29'd0, level}, m_cnt[DW-1:0]);
        check("tvalid", {31'd0, m_axis_tvalid}, {31'd0, (m_cnt != 0)});
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        check("tlast", {31'd0, m_axis_tlast}, 32'd1);
        vld_in        = v;
        data_in       = d;
        m_axis_tready = rdy;
        ovf_clr       = clr;
        pop_i = ((m_cnt != 0) && rdy) ? 1 : 0;
        acc_i = (v && ((m_cnt < DEPTH) || (pop_i == 1))) ? 1 : 0;
        if (acc_i == 1) exp_q.push_back(d);
        if (v && (acc_i == 0)) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_cnt = m_cnt + acc_i - pop_i;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (m_cnt != 0) step(1'b0, 32'd0, 1'b1, 1'b0);
        end
        check("drain_done", m_cnt[DW-1:0], 32'd0);
    endtask

    initial begin
        aresetn = 1'b0; vld_in = 1'b0; data_in = '0; m_axis_tready = 1'b0; ovf_clr = 1'b0;
        #2;
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_level", {29'd0, level}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_tlast", {31'd0, m_axis_tlast}, 32'd1);
        repeat (3) @(posedge clk);
        #1 aresetn = 1'b1;
        @(posedge clk); #1;

        // Single beat with consumer ready.
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // Fill to DEPTH under backpressure, then drain in order.
        for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        drain();

        // Overflow: push into full FIFO with no pop, then clear.
        for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b0);
        step(1'b1, 32'd5, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        drain();

        // Push into full FIFO concurrent with a pop.
        for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b0);
        step(1'b1, 32'd5, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        drain();

        // Set-and-clear in the same cycle: set wins.
        for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b0);
        step(1'b1, 32'd9, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        drain();

        // Random traffic with random backpressure.
        for (int i = 0; i < 1000; i++) begin
            step(($urandom % 2) == 0, $urandom, ($urandom % 2) == 0, ($urandom % 16) == 0);
        end
        drain();

        // Reset mid-burst with three entries pending and overflow set.
        for (int i = 1; i <= 4; i++) step(1'b1, 32'h100 + i, 1'b0, 1'b0);
        step(1'b1, 32'h1FF, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("pre_rst_level", {29'd0, level}, 32'd3);
        m_axis_tready = 1'b0;
        aresetn = 1'b0;
        #1;
        check("mid_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("mid_rst_level", {29'd0, level}, 32'd0);
        check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
        exp_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        vld_in = 1'b0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 32'h0000_00A5, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ovld_axis_adapter.md
# ovld_axis_adapter

Downstream adapter for the output-valid scalar register. It captures each single-cycle `vld_in`/`data_in` result pulse into a small FIFO and presents the results in order on an AXI4-Stream master port toward the data mover. The FIFO absorbs back-to-back accelerator completions while the stream consumer stalls. A sticky flag reports any result lost to overflow.

## Interface
Parameters:
- DATA_WIDTH, 32, width of the scalar result and of `m_axis_tdata`.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock, shared with the accelerator and the ovld register.
- aresetn  in  1  asynchronous, active-low reset.
- data_in  in  DATA_WIDTH  scalar result.
- vld_in  in  1  one-cycle push strobe; qualifies `data_in`.
- m_axis_tdata  out  DATA_WIDTH  head-of-FIFO result.
- m_axis_tvalid  out  1  FIFO not empty.
- m_axis_tready  in  1  consumer ready.
- m_axis_tlast  out  1  constant 1; each result is a one-beat packet.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; a push was dropped.
- ovf_clr  in  1  synchronous clear of `overflow`.

## Operation
- Push: on a `clk` edge with `vld_in`=1, write `data_in` at `wr_ptr` and increment `wr_ptr`. This happens only if the FIFO is not full, or if a pop occurs in the same cycle.
- Pop: on a `clk` edge with `m_axis_tvalid` & `m_axis_tready`, increment `rd_ptr`.
- Pointers:
  - `$clog2(DEPTH)+1` bits wide, with natural wrap.
  - empty when `wr_ptr`==`rd_ptr`.
  - full when the MSBs differ and the remaining bits are equal.
  - `level` = `wr_ptr` − `rd_ptr`, computed modulo 2^(`$clog2(DEPTH)`+1).
- Output drive:
  - `m_axis_tdata` = mem[`rd_ptr`], read combinationally from registered storage and a registered pointer.
  - `m_axis_tvalid` = !empty.
- AXIS rules:
  - `tdata` stays stable while `tvalid`=1 and `tready`=0.
  - `tvalid` never depends on `tready`.
  - `tvalid` drops only after the last pop.
- Simultaneous events:
  - Push and pop when empty: not possible, because `tvalid`=0 when empty. The push lands normally.
  - Push and pop when full: both happen; `level` stays at DEPTH and no overflow is flagged.
  - Push and pop at the same level: `level` is unchanged and ordering is preserved.
- Overflow:
  - Set on a push when full with no concurrent pop. The incoming data is discarded and the FIFO contents are untouched.
  - Cleared by `ovf_clr`=1. If a set and a clear happen in the same cycle, the set wins.
- Reset (async assert, sync-safe deassert by system):
  - pointers = 0, `overflow` = 0, so `m_axis_tvalid` = 0 and `level` = 0.
  - memory contents are not reset.
  - `m_axis_tlast` = 1 and `m_axis_tdata` is don't-care.
- Reset mid-transfer: all pending results are dropped. `tvalid` falls immediately, asynchronously.

## Timing
- Latency from a `vld_in` pulse on edge N into an empty FIFO: `m_axis_tvalid`=1 and `tdata`=value after edge N, i.e. in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- `level` and `overflow` update on the same edge as the push or pop that changes them.
- No combinational path from `vld_in`/`data_in` to any output.
- No combinational path from `m_axis_tready` to any output.

## Structure
- Shared package `ovld_pkg`:
  - default DATA_WIDTH.
  - a function computing the pointer width, `$clog2(DEPTH)+1`.
  - localparam `TLAST_PER_BEAT` = 1.
- Sub-module `ovld_sync_fifo`:
  - storage plus pointers plus full/empty/level logic.
  - push/pop strobes in; full/empty/level/head data out.
- The top level adds the push gating, the AXIS mapping and the overflow flag. Target is about 150–250 lines in total.

## Test plan
- Reset, then one pulse `vld_in` with `data_in`=0xDEADBEEF while `tready`=1 → `tvalid`=1 in the next cycle with `tdata`=0xDEADBEEF and `tlast`=1; one-beat handshake; then `tvalid`=0 and `level`=0.
- `tready`=0, four pulses of 0x1, 0x2, 0x3, 0x4 with DEPTH=4 → `level`=4, `overflow`=0; then with `tready`=1 the beats come out in order 0x1..0x4 on consecutive cycles.
- FIFO full, `tready`=0, push 0x5 → `overflow`=1, `level`=4, and the drained output is still 0x1..0x4. Then `ovf_clr` for one cycle → `overflow`=0.
- FIFO full, `tready`=1, push 0x5 in the same cycle as popping 0x1 → `overflow`=0, `level`=4, output sequence 0x2, 0x3, 0x4, 0x5.
- Random `tready` backpressure with 1000 random pushes at about 50% rate → scoreboard matches in order; `tdata` is stable while stalled; `overflow` is set exactly when the model predicts a drop.
- Assert `aresetn`=0 mid-burst with `level`=3 → `tvalid`, `level` and `overflow` go to 0 immediately. After release, a new push of 0xA5 emerges as the first beat.
